batcharger_ctrl: RTL and testbench
==================================

Name: batcharger_ctrl

Overview:
- Digital charge-control FSM that drives the BATCHARGER pad-ring inputs `en` and `sel[3:0]`. It closes the loop from the opposite side: it consumes ADC samples of battery voltage, temperature and current.
- Sequences the charge as PRECHARGE → CC → CV → DONE, with temperature fault and timeout supervision.
- Sits in the digital domain, between the ADC result interface and the charger core enable/selection pads.

Parameters:
- ADC_W, 8, width of the ADC sample codes.
- DEB, 3, number of consecutive qualifying samples required for a threshold transition.
- VPRE, 96, vbat code below which charging starts in PRECHARGE.
- VCV, 200, vbat code at or above which CC hands over to CV.
- VRCH, 190, vbat code below which DONE restarts charging.
- ITERM, 10, ibat code at or below which CV terminates.
- TMIN, 40, lowest allowed vtemp code (inclusive).
- TMAX, 200, highest allowed vtemp code (inclusive).
- TMR_W, 20, width of the state timer.
- PRE_TMO, 20'hFFFFF, clock cycles allowed in PRECHARGE before FAULT.
- CV_TMO, 20'hFFFFF, clock cycles allowed in CV before forced DONE.

Ports:
- clk  input  1  system clock
- rstz  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin charging; honoured only in IDLE
- stop  input  1  abort/clear request; honoured in every state
- cfg_sel  input  4  battery capacity code, latched on an accepted start
- adc_valid  input  1  one-cycle strobe; vbat, vtemp and ibat are valid together with it
- vbat  input  ADC_W  battery voltage sample
- vtemp  input  ADC_W  normalised temperature sample
- ibat  input  ADC_W  charge current sample
- en  output  1  charger core enable
- sel  output  4  capacity selection to the charger core
- state  output  3  encoding: IDLE=0, CHECK=1, PRE=2, CC=3, CV=4, DONE=5, FAULT=6
- done  output  1  high while in DONE
- fault  output  1  high while in FAULT

Behaviour:
- Reset: rstz low asynchronously forces `state`=IDLE, `en`=0, `sel`=0, `done`=0, `fault`=0, sel_q=0, debounce counter=0, timer=0.
- Output timing: all outputs are registered and reflect the current state.
  - `en`=1 exactly in PRE, CC and CV.
  - `sel`=0 in PRE (minimum current). `sel`=sel_q in CC and CV. `sel`=0 elsewhere.
- Sample evaluation: thresholds are evaluated only on cycles with adc_valid=1; all comparisons are unsigned.
- Temperature check: in CHECK, PRE, CC, CV and DONE, a valid sample with vtemp<TMIN or vtemp>TMAX moves to FAULT on the next edge. This has priority over every other threshold transition.
- stop priority: `stop`=1 moves any state to IDLE on the next edge and clears done, fault and the counters. stop wins over a simultaneous start and over simultaneous ADC events.
- IDLE: start=1 latches cfg_sel into sel_q and moves to CHECK. start in any other state is ignored.
- CHECK: on the first valid sample with temperature in range:
  - vbat<VPRE → PRE
  - VPRE≤vbat<VCV → CC
  - vbat≥VCV → CV
  - No debounce is applied in CHECK.
- PRE: DEB consecutive samples with vbat≥VPRE → CC. Timer reaching PRE_TMO-1 → FAULT.
- CC: DEB consecutive samples with vbat≥VCV → CV. There is no timeout.
- CV: DEB consecutive samples with ibat≤ITERM → DONE. Timer reaching CV_TMO-1 → DONE (forced termination).
- DONE: `en`=0 and `done`=1. DEB consecutive samples with vbat<VRCH → CC; sel_q is retained and done clears on entry to CC.
- FAULT: `en`=0 and `fault`=1. The state is sticky and is left only by stop.
- Debounce counter:
  - Increments on each qualifying valid sample and saturates at DEB.
  - Clears on a valid non-qualifying sample and on every state change.
  - Cycles with adc_valid=0 leave it unchanged.
  - The transition fires on the edge where the DEB-th qualifying sample is seen.
- Timer: counts clk cycles, is cleared on every state entry, and saturates.
- Simultaneous events: if a timeout and a debounce completion coincide, the timeout wins in PRE (FAULT). In CV both lead to DONE.

Test Plan:
- Reset mid-CC: rstz pulsed low with state=3 → en=0, sel=0, state=0 immediately, with no clock needed.
- start with cfg_sel=4'b1010, then samples vbat=50, vtemp=100, ibat=80 → state=2, en=1, sel=0. Three samples of vbat=100 → state=3, sel=1010. Three samples of vbat=205 → state=4.
- CV termination debounce: ibat=8, 8, 12, 8, 8, 8 → no DONE after the 12. DONE (done=1, en=0) on the edge of the 6th sample.
- Temperature fault in CC: one sample with vtemp=210 → state=6, fault=1, en=0 next cycle. A later start is ignored. stop → state=0, fault=0.
- Recharge: in DONE, vbat=185 ×3 → state=3, en=1, done=0, sel unchanged. start and stop asserted in the same cycle in IDLE → stays IDLE.
- PRE timeout with PRE_TMO=16: vbat held at 50 → FAULT exactly 16 cycles after PRE entry.

Source files
------------

// File: rtl/batcharger_ctrl.sv
// batcharger_ctrl
//   Charge-control FSM for the BATCHARGER pad ring. Consumes ADC samples of
//   battery voltage, temperature and charge current, and sequences
//   PRECHARGE -> CC -> CV -> DONE with temperature-fault and timeout
//   supervision. Drives the charger core enable and capacity select pads.
//
// Ports
//   clk        system clock
//   rstz       asynchronous active-low reset
//   start      one-cycle charge request, honoured only in IDLE
//   stop       abort/clear request, honoured in every state
//   cfg_sel    battery capacity code, latched on an accepted start
//   adc_valid  strobe qualifying vbat/vtemp/ibat
//   vbat       battery voltage sample
//   vtemp      normalised temperature sample
//   ibat       charge current sample
//   en         charger core enable (PRE, CC, CV)
//   sel        capacity selection (0 in PRE, latched code in CC/CV)
//   state      IDLE=0 CHECK=1 PRE=2 CC=3 CV=4 DONE=5 FAULT=6
//   done       high while in DONE
//   fault      high while in FAULT
module batcharger_ctrl #(
  parameter int unsigned ADC_W = 8,
  parameter int unsigned DEB   = 3,
  parameter int unsigned VPRE  = 96,
  parameter int unsigned VCV   = 200,
  parameter int unsigned VRCH  = 190,
  parameter int unsigned ITERM = 10,
  parameter int unsigned TMIN  = 40,
  parameter int unsigned TMAX  = 200,
  parameter int unsigned TMR_W = 20,
  parameter logic [TMR_W-1:0] PRE_TMO = 20'hFFFFF,
  parameter logic [TMR_W-1:0] CV_TMO  = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       cfg_sel,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] vbat,
  input  logic [ADC_W-1:0] vtemp,
  input  logic [ADC_W-1:0] ibat,
  output logic             en,
  output logic [3:0]       sel,
  output logic [2:0]       state,
  output logic             done,
  output logic             fault
);

  localparam int unsigned DEB_W = (DEB < 1) ? 1 : $clog2(DEB + 1);

  localparam logic [ADC_W-1:0] VPRE_C  = ADC_W'(VPRE);
  localparam logic [ADC_W-1:0] VCV_C   = ADC_W'(VCV);
  localparam logic [ADC_W-1:0] VRCH_C  = ADC_W'(VRCH);
  localparam logic [ADC_W-1:0] ITERM_C = ADC_W'(ITERM);
  localparam logic [ADC_W-1:0] TMIN_C  = ADC_W'(TMIN);
  localparam logic [ADC_W-1:0] TMAX_C  = ADC_W'(TMAX);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);
  localparam logic [TMR_W-1:0] PRE_LAST = PRE_TMO - TMR_W'(1);
  localparam logic [TMR_W-1:0] CV_LAST  = CV_TMO - TMR_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    PRE   = 3'd2,
    CC    = 3'd3,
    CV    = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         sel_q, sel_q_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               en_q, done_q, fault_q;
  logic [3:0]         sel_out_q;

  logic               temp_bad;
  logic               qual;
  logic               deb_hit;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      deb_q     <= '0;
      tmr_q     <= '0;
      en_q      <= 1'b0;
      sel_out_q <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_q_d;
      deb_q     <= deb_d;
      tmr_q     <= tmr_d;
      // Outputs are registered from the next state so they change on the
      // same edge as the state register.
      en_q      <= (state_d == PRE) || (state_d == CC) || (state_d == CV);
      sel_out_q <= ((state_d == CC) || (state_d == CV)) ? sel_q_d : '0;
      done_q    <= (state_d == DONE);
      fault_q   <= (state_d == FAULT);
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_q_d  = sel_q;
    deb_d    = deb_q;
    tmr_d    = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
    qual     = 1'b0;
    temp_bad = adc_valid && ((vtemp < TMIN_C) || (vtemp > TMAX_C));

    case (state_q)
      PRE:     qual = (vbat >= VPRE_C);
      CC:      qual = (vbat >= VCV_C);
      CV:      qual = (ibat <= ITERM_C);
      DONE:    qual = (vbat < VRCH_C);
      default: qual = 1'b0;
    endcase

    // The DEB-th qualifying sample completes the debounce on this edge.
    deb_hit = adc_valid && qual && (deb_q == DEB_LAST);

    if (adc_valid) begin
      if (qual) begin
        deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + DEB_W'(1);
      end else begin
        deb_d = '0;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_q_d = cfg_sel;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (temp_bad) begin
          state_d = FAULT;
        end else if (adc_valid) begin
          if (vbat < VPRE_C)      state_d = PRE;
          else if (vbat < VCV_C)  state_d = CC;
          else                    state_d = CV;
        end
      end
      PRE: begin
        if (temp_bad || (tmr_q == PRE_LAST)) state_d = FAULT;
        else if (deb_hit)                    state_d = CC;
      end
      CC: begin
        if (temp_bad)     state_d = FAULT;
        else if (deb_hit) state_d = CV;
      end
      CV: begin
        if (temp_bad)                          state_d = FAULT;
        else if ((tmr_q == CV_LAST) || deb_hit) state_d = DONE;
      end
      DONE: begin
        if (temp_bad)     state_d = FAULT;
        else if (deb_hit) state_d = CC;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
    end

    // Every state change, including a stop, restarts debounce and timer.
    if (stop || (state_d != state_q)) begin
      deb_d = '0;
      tmr_d = '0;
    end
  end

  assign state = state_q;
  assign en    = en_q;
  assign sel   = sel_out_q;
  assign done  = done_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// tb_batcharger_ctrl
//   Directed scoreboard bench for batcharger_ctrl. Stimulus pushes the
//   expected registered outputs after each edge; a monitor pops and compares
//   on the falling edge (or on an explicit strobe for asynchronous reset).
module tb_batcharger_ctrl;

  logic       clk = 1'b0;
  logic       rstz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] cfg_sel = '0;
  logic       adc_valid = 1'b0;
  logic [7:0] vbat = '0;
  logic [7:0] vtemp = '0;
  logic [7:0] ibat = '0;
  logic       en;
  logic [3:0] sel;
  logic [2:0] state;
  logic       done;
  logic       fault;
  logic       async_chk = 1'b0;

  typedef struct {
    string      nm;
    logic [2:0] st;
    logic       en;
    logic [3:0] sel;
    logic       done;
    logic       fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  batcharger_ctrl #(
    .ADC_W   (8),
    .DEB     (3),
    .PRE_TMO (20'd16)
  ) dut (
    .clk       (clk),
    .rstz      (rstz),
    .start     (start),
    .stop      (stop),
    .cfg_sel   (cfg_sel),
    .adc_valid (adc_valid),
    .vbat      (vbat),
    .vtemp     (vtemp),
    .ibat      (ibat),
    .en        (en),
    .sel       (sel),
    .state     (state),
    .done      (done),
    .fault     (fault)
  );

  // Monitor
  always @(negedge clk or posedge async_chk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({state, en, sel, done, fault} !== {e.st, e.en, e.sel, e.done, e.fault}) begin
        errors++;
        $display("FAIL %s: got state=%0d en=%0b sel=%b done=%0b fault=%0b, expected state=%0d en=%0b sel=%b done=%0b fault=%0b",
                 e.nm, state, en, sel, done, fault, e.st, e.en, e.sel, e.done, e.fault);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [2:0] s, input logic e,
                            input logic [3:0] sl, input logic d, input logic f);
    exp_t x;
    x.nm = nm; x.st = s; x.en = e; x.sel = sl; x.done = d; x.fault = f;
    exp_q.push_back(x);
  endtask

  // One clock edge; expected values describe the outputs after that edge.
  task automatic tick(input string nm, input logic [2:0] s, input logic e,
                      input logic [3:0] sl, input logic d, input logic f);
    @(posedge clk);
    expect_out(nm, s, e, sl, d, f);
    #1;
    start     = 1'b0;
    stop      = 1'b0;
    adc_valid = 1'b0;
  endtask

  task automatic sample(input logic [7:0] v, input logic [7:0] t, input logic [7:0] i);
    adc_valid = 1'b1;
    vbat      = v;
    vtemp     = t;
    ibat      = i;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, checked while rstz is still low
    #1;
    expect_out("reset_state", 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    async_chk = 1'b1; #1; async_chk = 1'b0;
    @(negedge clk); #1 rstz = 1'b1;
    @(posedge clk); #1;

    // Start and CHECK -> PRE (vtemp at TMIN is still in range)
    start = 1'b1; cfg_sel = 4'b1010;
    tick("start_to_check", 3'd1, 1'b0, 4'b0000, 1'b0, 1'b0);
    sample(8'd50, 8'd40, 8'd80);
    tick("check_to_pre", 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0);

    // PRE debounce, with an invalid cycle that must not reset the count
    sample(8'd100, 8'd100, 8'd80);
    tick("pre_deb1", 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0);
    tick("pre_novalid", 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0);
    sample(8'd100, 8'd100, 8'd80);
    tick("pre_deb2", 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0);
    sample(8'd100, 8'd100, 8'd80);
    tick("pre_to_cc", 3'd3, 1'b1, 4'b1010, 1'b0, 1'b0);

    // CC -> CV (vtemp at TMAX is still in range)
    sample(8'd205, 8'd200, 8'd80);
    tick("cc_deb1", 3'd3, 1'b1, 4'b1010, 1'b0, 1'b0);
    sample(8'd205, 8'd200, 8'd80);
    tick("cc_deb2", 3'd3, 1'b1, 4'b1010, 1'b0, 1'b0);
    sample(8'd205, 8'd200, 8'd80);
    tick("cc_to_cv", 3'd4, 1'b1, 4'b1010, 1'b0, 1'b0);

    // CV termination debounce broken by a non-qualifying sample
    sample(8'd205, 8'd100, 8'd8);
    tick("cv_i8_a", 3'd4, 1'b1, 4'b1010, 1'b0, 1'b0);
    sample(8'd205, 8'd100, 8'd8);
    tick("cv_i8_b", 3'd4, 1'b1, 4'b1010, 1'b0, 1'b0);
    sample(8'd205, 8'd100, 8'd12);
    tick("cv_i12", 3'd4, 1'b1, 4'b1010, 1'b0, 1'b0);
    sample(8'd205, 8'd100, 8'd8);
    tick("cv_i8_c", 3'd4, 1'b1, 4'b1010, 1'b0, 1'b0);
    sample(8'd205, 8'd100, 8'd8);
    tick("cv_i8_d", 3'd4, 1'b1, 4'b1010, 1'b0, 1'b0);
    sample(8'd205, 8'd100, 8'd8);
    tick("cv_to_done", 3'd5, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Recharge from DONE
    sample(8'd185, 8'd100, 8'd0);
    tick("done_deb1", 3'd5, 1'b0, 4'b0000, 1'b1, 1'b0);
    sample(8'd185, 8'd100, 8'd0);
    tick("done_deb2", 3'd5, 1'b0, 4'b0000, 1'b1, 1'b0);
    sample(8'd185, 8'd100, 8'd0);
    tick("recharge_cc", 3'd3, 1'b1, 4'b1010, 1'b0, 1'b0);

    // Temperature fault in CC, sticky, cleared only by stop
    sample(8'd150, 8'd210, 8'd80);
    tick("cc_temp_fault", 3'd6, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick("fault_hold", 3'd6, 1'b0, 4'b0000, 1'b0, 1'b1);
    start = 1'b1; cfg_sel = 4'b0101;
    tick("fault_start_ignored", 3'd6, 1'b0, 4'b0000, 1'b0, 1'b1);
    stop = 1'b1;
    tick("fault_stop", 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // stop beats start in IDLE
    start = 1'b1; stop = 1'b1; cfg_sel = 4'b1111;
    tick("idle_start_stop", 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // PRE timeout: 16 cycles after PRE entry
    start = 1'b1; cfg_sel = 4'b0011;
    tick("tmo_start", 3'd1, 1'b0, 4'b0000, 1'b0, 1'b0);
    sample(8'd50, 8'd100, 8'd0);
    tick("tmo_pre_entry", 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      sample(8'd50, 8'd100, 8'd0);
      tick($sformatf("tmo_pre_%0d", i), 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0);
    end
    sample(8'd50, 8'd100, 8'd0);
    tick("tmo_fault", 3'd6, 1'b0, 4'b0000, 1'b0, 1'b1);
    stop = 1'b1;
    tick("tmo_stop", 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // CHECK straight to CC, then asynchronous reset with no clock edge
    start = 1'b1; cfg_sel = 4'b0110;
    tick("rst_start", 3'd1, 1'b0, 4'b0000, 1'b0, 1'b0);
    sample(8'd100, 8'd100, 8'd80);
    tick("check_to_cc", 3'd3, 1'b1, 4'b0110, 1'b0, 1'b0);
    @(negedge clk); #1;
    rstz = 1'b0; #1;
    expect_out("async_reset_mid_cc", 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    async_chk = 1'b1; #1; async_chk = 1'b0;
    @(negedge clk); #1 rstz = 1'b1;
    @(posedge clk); #1;
    tick("post_reset_idle", 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Drain scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
